// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// Optional leading-zero blank mask enabled by defining BCD_BLANK_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int SCR_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int LIM_W = BIN_W + 5;

    // 10^DIGITS clipped to 2^BIN_W: a clipped limit can never be reached,
    // so the overflow compare folds to constant 0 without width errors.
    function automatic logic [LIM_W-1:0] pow10_clip();
        logic [LIM_W-1:0] r;
        r = LIM_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            r = r * LIM_W'(10);
            if (r >= (LIM_W'(1) << BIN_W)) begin
                r = LIM_W'(1) << BIN_W;
            end
        end
        return r;
    endfunction

    localparam logic [LIM_W-1:0] LIMIT = pow10_clip();

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [SCR_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_flag_q, ovf_flag_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;

    logic [SCR_W-1:0]       adj;
    logic [SCR_W-1:0]       shifted;
    logic [4*DIGITS-1:0]    bcd_next;
    logic                   ovf_cmp;

    assign ovf_cmp = ({5'b0, bin_in} >= LIMIT);

    // Add-3 correction on every nibble, guard included, before the shift.
    always_comb begin
        adj = '0;
        for (int n = 0; n <= DIGITS; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end else begin
                adj[4*n +: 4] = scratch_q[4*n +: 4];
            end
        end
        shifted  = SCR_W'({adj, bin_q[BIN_W-1]});
        bcd_next = ovf_flag_q ? {DIGITS{4'h9}} : shifted[4*DIGITS-1:0];
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_next;
    logic              all_zero;

    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (bcd_next[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
        if (ovf_flag_q) begin
            blank_next = '0;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
`ifdef BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_flag_d = ovf_cmp;
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = shifted;
                bin_d     = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_next;
                    ovf_d   = ovf_flag_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`ifdef BCD_BLANK_EN
                    blank_d = blank_next;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
`ifdef BCD_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        ovf;
    logic [7:0]  blank;

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .blank   (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blk;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_blank(input logic [7:0] b);
`ifdef BCD_BLANK_EN
        return b;
`else
        return 8'h00 & b;
`endif
    endfunction

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called #1 after a rising edge with the converter idle.
    task automatic run_conv(input logic [26:0] v, output int edges, output int busy_cnt);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        while (edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            if (busy) busy_cnt++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int edges, bcnt, dn, e, n;
        int t[3];
        logic prev_done;
        logic nib_ok;
        int unsigned rv;

        vecs[0]  = '{27'd0,         32'h00000000, 1'b0, 8'b11111110};
        vecs[1]  = '{27'd12345678,  32'h12345678, 1'b0, 8'b00000000};
        vecs[2]  = '{27'd99999999,  32'h99999999, 1'b0, 8'b00000000};
        vecs[3]  = '{27'h7FFFFFF,   32'h99999999, 1'b1, 8'b00000000};
        vecs[4]  = '{27'd305,       32'h00000305, 1'b0, 8'b11111000};
        vecs[5]  = '{27'd100000000, 32'h99999999, 1'b1, 8'b00000000};
        vecs[6]  = '{27'd7,         32'h00000007, 1'b0, 8'b11111110};
        vecs[7]  = '{27'd10000000,  32'h10000000, 1'b0, 8'b00000000};
        vecs[8]  = '{27'd42,        32'h00000042, 1'b0, 8'b11111100};
        vecs[9]  = '{27'd10,        32'h00000010, 1'b0, 8'b11111100};
        vecs[10] = '{27'd1000,      32'h00001000, 1'b0, 8'b11110000};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_blank", blank, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency and busy width for value 0
        run_conv(27'd0, edges, bcnt);
        check("lat_edges", edges, 27);
        check("lat_busy_cycles", bcnt, 27);
        check("lat_busy_low_at_done", busy, 0);
        check("zero_bcd", bcd_out, 32'h0);
        check("zero_ovf", ovf, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("bcd_holds", bcd_out, 32'h0);

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].bin, edges, bcnt);
            check($sformatf("vec%0d_bcd", i), bcd_out, vecs[i].bcd);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            check($sformatf("vec%0d_blank", i), blank, exp_blank(vecs[i].blk));
            check($sformatf("vec%0d_lat", i), edges, 27);
        end

        // Start while busy is ignored
        bin_in = 27'd305;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_during_ignored_start", busy, 1);
        bin_in = 27'd42;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("ignored_start_done_count", dn, 1);
        check("ignored_start_bcd", bcd_out, 32'h00000305);

        // Start held high: conversions every 28 cycles
        bin_in    = 27'd5;
        start     = 1'b1;
        e         = 0;
        n         = 0;
        prev_done = 1'b0;
        while (n < 3 && e < 200) begin
            @(posedge clk);
            #1;
            e++;
            if (prev_done) begin
                check("held_next_done", done, 0);
                check("held_next_busy", busy, 1);
            end
            prev_done = done;
            if (done) begin
                t[n] = e;
                n++;
            end
        end
        start = 1'b0;
        check("held_done_count", n, 3);
        check("held_spacing1", t[1] - t[0], 28);
        check("held_spacing2", t[2] - t[1], 28);
        check("held_bcd", bcd_out, 32'h00000005);

        // Reset mid-conversion
        bin_in = 27'd87654321;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd_out, 0);
        #2;
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("midrst_no_done", dn, 0);
        check("midrst_bcd_after", bcd_out, 0);
        check("midrst_busy_after", busy, 0);
        check("midrst_ovf_after", ovf, 0);
        run_conv(27'd7, edges, bcnt);
        check("post_rst_bcd", bcd_out, 32'h00000007);

        // Back-to-back random values against the decimal model
        for (int k = 0; k < 1000; k++) begin
            rv = $urandom_range(99999999, 0);
            run_conv(27'(rv), edges, bcnt);
            nib_ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (bcd_out[4*j +: 4] > 4'd9) nib_ok = 1'b0;
            end
            check($sformatf("rand%0d_nibbles", k), nib_ok, 1);
            check($sformatf("rand%0d_bcd_%0d", k, rv), bcd_out, ref_bcd(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
